rtu_rsp_dispatcher: RTL and testbench



---
 rtl/rtu_rsp_dispatcher_pkg.sv | 25 ++
 rtl/rtu_rsp_dispatcher_if.sv | 36 +++
 rtl/rtu_rsp_port_fifo.sv | 67 ++++++
 rtl/rtu_rsp_dispatcher.sv | 83 ++++++++
 tb/tb_rtu_rsp_dispatcher.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/rtu_rsp_dispatcher_pkg.sv
// rtl/rtu_rsp_dispatcher_pkg.sv - shared types, default widths and sizing helper for the RTU response dispatcher
// Contents: default parameter constants, t_rtu_rsp record, f_log2_size().
package rtu_rsp_pkg;

  localparam int c_num_ports  = 7;
  localparam int c_prio_width = 3;
  localparam int c_fifo_depth = 2;

  // One queued response at the default widths.
  typedef struct packed {
    logic [c_num_ports-1:0]  mask;
    logic                    drop;
    logic [c_prio_width-1:0] prio;
  } t_rtu_rsp;

  // Bits needed to index n items; never less than 1 so single-item
  // configurations still get a legal vector width.
  function automatic int f_log2_size(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rtu_rsp_dispatcher_if.sv
// rtl/rtu_rsp_dispatcher_if.sv - result-input channel and per-port response lanes of the dispatcher
// master: the dispatcher (takes res_* and acks, drives ready, lanes and err)
// slave : the environment (match engine + swcore side)
interface rtu_rsp_dispatcher_if
  import rtu_rsp_pkg::*;
#(
  parameter int g_num_ports  = c_num_ports,
  parameter int g_prio_width = c_prio_width
);

  localparam int c_port_w = f_log2_size(g_num_ports);

  logic                                res_valid_i;
  logic                                res_ready_o;
  logic [c_port_w-1:0]                 res_port_i;
  logic [g_num_ports-1:0]              res_mask_i;
  logic                                res_drop_i;
  logic [g_prio_width-1:0]             res_prio_i;
  logic [g_num_ports-1:0]              rtu_rsp_valid_o;
  logic [g_num_ports-1:0]              rtu_rsp_ack_i;
  logic [g_num_ports*g_num_ports-1:0]  rtu_dst_port_mask_o;
  logic [g_num_ports-1:0]              rtu_drop_o;
  logic [g_num_ports*g_prio_width-1:0] rtu_prio_o;
  logic                                err_o;

  modport master (
    input  res_valid_i, res_port_i, res_mask_i, res_drop_i, res_prio_i, rtu_rsp_ack_i,
    output res_ready_o, rtu_rsp_valid_o, rtu_dst_port_mask_o, rtu_drop_o, rtu_prio_o, err_o
  );

  modport slave (
    output res_valid_i, res_port_i, res_mask_i, res_drop_i, res_prio_i, rtu_rsp_ack_i,
    input  res_ready_o, rtu_rsp_valid_o, rtu_dst_port_mask_o, rtu_drop_o, rtu_prio_o, err_o
  );

endinterface

// File: rtl/rtu_rsp_port_fifo.sv
// rtl/rtu_rsp_port_fifo.sv - per-port response FIFO with occupancy counter
// Ports: clk_i, rst_i (sync, active-high), push_i/data_i, pop_i,
//        full_o/empty_o, data_o (head entry, all-zero while empty).
module rtu_rsp_port_fifo
  import rtu_rsp_pkg::*;
#(
  parameter int g_depth = 2,
  parameter int g_width = 11
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [g_width-1:0] data_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [g_width-1:0] data_o
);

  localparam int c_ptr_w = f_log2_size(g_depth);

  logic [g_width-1:0] mem_q [g_depth];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  // One extra bit so full (== depth) and empty (== 0) never alias.
  logic [c_ptr_w:0]   cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign full_o  = (cnt_q == (c_ptr_w+1)'(g_depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (c_ptr_w+1)'(1);
      2'b01:   cnt_d = cnt_q - (c_ptr_w+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/rtu_rsp_dispatcher.sv
// rtl/rtu_rsp_dispatcher.sv - queues RTU lookup results per ingress port and presents them on swcore response lanes
// Ports: clk_i, rst_i (sync, active-high), bus (rtu_rsp_dispatcher_if.master):
//        res_* result input with res_ready_o, per-port rtu_rsp_* lanes with acks, err_o.
module rtu_rsp_dispatcher
  import rtu_rsp_pkg::*;
#(
  parameter int g_num_ports  = c_num_ports,
  parameter int g_prio_width = c_prio_width,
  parameter int g_fifo_depth = c_fifo_depth
) (
  input logic                  clk_i,
  input logic                  rst_i,
  rtu_rsp_dispatcher_if.master bus
);

  localparam int c_entry_w = g_num_ports + 1 + g_prio_width;

  logic [g_num_ports-1:0]              sel, push, pop, full, empty;
  logic                                port_ok, ready;
  logic                                err_q, err_d;
  logic [g_num_ports-1:0]              stored_mask;
  logic [c_entry_w-1:0]                entry;
  logic [c_entry_w-1:0]                head [g_num_ports];
  logic [g_num_ports*g_num_ports-1:0]  mask_lanes;
  logic [g_num_ports-1:0]              drop_lanes;
  logic [g_num_ports*g_prio_width-1:0] prio_lanes;

  always_comb begin
    sel = '0;
    for (int p = 0; p < g_num_ports; p++) begin
      sel[p] = (32'(bus.res_port_i) == p);
    end
    port_ok = |sel;
    // Out-of-range ports are always accepted so they can be dropped.
    ready = port_ok ? |(sel & ~full) : 1'b1;
    push  = {g_num_ports{bus.res_valid_i & ready}} & sel;
    pop   = bus.rtu_rsp_ack_i & ~empty;
    // sel doubles as the self-bit: a frame is never sent back where it came in.
    stored_mask = bus.res_drop_i ? '0 : (bus.res_mask_i & ~sel);
    entry = {stored_mask, bus.res_drop_i, bus.res_prio_i};
    err_d = bus.res_valid_i & ~port_ok;
  end

  for (genvar p = 0; p < g_num_ports; p++) begin : g_port
    rtu_rsp_port_fifo #(
      .g_depth (g_fifo_depth),
      .g_width (c_entry_w)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push[p]),
      .data_i  (entry),
      .pop_i   (pop[p]),
      .full_o  (full[p]),
      .empty_o (empty[p]),
      .data_o  (head[p])
    );
  end

  always_comb begin
    mask_lanes = '0;
    drop_lanes = '0;
    prio_lanes = '0;
    for (int p = 0; p < g_num_ports; p++) begin
      mask_lanes[p*g_num_ports +: g_num_ports]   = head[p][c_entry_w-1 -: g_num_ports];
      drop_lanes[p]                              = head[p][g_prio_width];
      prio_lanes[p*g_prio_width +: g_prio_width] = head[p][g_prio_width-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.res_ready_o         = ready;
  assign bus.rtu_rsp_valid_o     = ~empty;
  assign bus.rtu_dst_port_mask_o = mask_lanes;
  assign bus.rtu_drop_o          = drop_lanes;
  assign bus.rtu_prio_o          = prio_lanes;
  assign bus.err_o               = err_q;

endmodule

// File: tb/tb_rtu_rsp_dispatcher.sv
// tb/tb_rtu_rsp_dispatcher.sv - self-checking bench for rtu_rsp_dispatcher against a per-port queue model
module tb_rtu_rsp_dispatcher;
  import rtu_rsp_pkg::*;

  localparam int N     = 7;
  localparam int PW    = 3;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  t_rtu_rsp model_q [N][$];

  rtu_rsp_dispatcher_if #(.g_num_ports(N), .g_prio_width(PW)) bus();

  rtu_rsp_dispatcher #(
    .g_num_ports  (N),
    .g_prio_width (PW),
    .g_fifo_depth (DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check ready before the edge, advance the
  // model at the edge, check lanes at the following negedge.
  task automatic cycle(input logic r, input logic v, input int port, input logic [N-1:0] mask,
                       input logic drop, input logic [PW-1:0] prio, input logic [N-1:0] ack);
    bit                exp_ready, exp_err;
    t_rtu_rsp          e;
    logic [N-1:0]      ev, ed;
    logic [N*N-1:0]    em;
    logic [N*PW-1:0]   ep;
    rst               = r;
    bus.res_valid_i   = v;
    bus.res_port_i    = 3'(port);
    bus.res_mask_i    = mask;
    bus.res_drop_i    = drop;
    bus.res_prio_i    = prio;
    bus.rtu_rsp_ack_i = ack;
    #1;
    exp_ready = (port >= N) ? 1'b1 : (model_q[port].size() < DEPTH);
    check("res_ready", bus.res_ready_o, exp_ready);
    @(posedge clk);
    exp_err = 1'b0;
    if (r) begin
      for (int p = 0; p < N; p++) model_q[p].delete();
    end else begin
      for (int p = 0; p < N; p++)
        if (ack[p] && model_q[p].size() > 0) void'(model_q[p].pop_front());
      if (v && port < N && exp_ready) begin
        e.mask = drop ? '0 : (mask & ~(N'(1) << port));
        e.drop = drop;
        e.prio = prio;
        model_q[port].push_back(e);
      end
      exp_err = v && (port >= N);
    end
    @(negedge clk);
    ev = '0; ed = '0; em = '0; ep = '0;
    for (int p = 0; p < N; p++) begin
      if (model_q[p].size() > 0) begin
        ev[p]          = 1'b1;
        em[p*N +: N]   = model_q[p][0].mask;
        ed[p]          = model_q[p][0].drop;
        ep[p*PW +: PW] = model_q[p][0].prio;
      end
    end
    check("rsp_valid", bus.rtu_rsp_valid_o, ev);
    check("dst_mask", bus.rtu_dst_port_mask_o, em);
    check("drop", bus.rtu_drop_o, ed);
    check("prio", bus.rtu_prio_o, ep);
    check("err", bus.err_o, exp_err);
  endtask

  task automatic idle(input logic [N-1:0] ack);
    cycle(1'b0, 1'b0, 0, '0, 1'b0, '0, ack);
  endtask

  task automatic push(input int port, input logic [N-1:0] mask, input logic drop,
                      input logic [PW-1:0] prio, input logic [N-1:0] ack);
    cycle(1'b0, 1'b1, port, mask, drop, prio, ack);
  endtask

  initial begin
    rst = 1'b1;
    bus.res_valid_i   = 1'b0;
    bus.res_port_i    = '0;
    bus.res_mask_i    = '0;
    bus.res_drop_i    = 1'b0;
    bus.res_prio_i    = '0;
    bus.rtu_rsp_ack_i = '0;
    @(negedge clk);
    @(negedge clk);
    cycle(1'b1, 1'b0, 0, '0, 1'b0, '0, '0);

    // Basic push/ack on port 2 with self-bit clear.
    push(2, 7'h7F, 1'b0, 3'd5, '0);
    check("s1_valid", bus.rtu_rsp_valid_o, 7'h04);
    check("s1_mask", bus.rtu_dst_port_mask_o[20:14], 7'h7B);
    check("s1_prio", bus.rtu_prio_o[8:6], 3'd5);
    idle(7'h04);
    check("s1_clear", bus.rtu_rsp_valid_o, 7'h00);

    // Depth limit on port 0 and FIFO order.
    push(0, 7'h0E, 1'b0, 3'd1, '0);
    push(0, 7'h12, 1'b0, 3'd2, '0);
    check("s2_ready_full", bus.res_ready_o, 1'b0);
    push(0, 7'h22, 1'b0, 3'd3, '0);
    check("s2_head1", bus.rtu_prio_o[2:0], 3'd1);
    idle(7'h01);
    check("s2_head2", bus.rtu_prio_o[2:0], 3'd2);
    idle(7'h01);
    check("s2_empty", bus.rtu_rsp_valid_o[0], 1'b0);

    // Streaming on port 4 with ack held high.
    for (int i = 0; i < 6; i++) push(4, 7'(8 * i + 3), 1'b0, 3'(i), 7'h10);
    idle(7'h10);

    // Drop gating on port 1.
    push(1, 7'h3C, 1'b1, 3'd6, '0);
    check("s4_drop", bus.rtu_drop_o[1], 1'b1);
    check("s4_mask", bus.rtu_dst_port_mask_o[13:7], 7'h00);
    idle(7'h02);

    // Out-of-range port.
    push(7, 7'h55, 1'b0, 3'd2, '0);
    check("s5_err", bus.err_o, 1'b1);
    check("s5_no_valid", bus.rtu_rsp_valid_o, 7'h00);
    idle('0);

    // Fill everything, then reset together with acks on every lane.
    for (int p = 0; p < N; p++) begin
      push(p, 7'h7F, 1'b0, 3'(p), '0);
      push(p, 7'h41, 1'b0, 3'(p + 1), '0);
    end
    check("s6_full_valid", bus.rtu_rsp_valid_o, 7'h7F);
    cycle(1'b1, 1'b0, 0, '0, 1'b0, '0, 7'h7F);
    check("s6_rst_valid", bus.rtu_rsp_valid_o, 7'h00);
    check("s6_rst_mask", bus.rtu_dst_port_mask_o, 49'h0);
    push(2, 7'h7F, 1'b0, 3'd5, '0);
    check("s6_repush_mask", bus.rtu_dst_port_mask_o[20:14], 7'h7B);
    idle(7'h04);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
            7'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom), 7'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
